// File: rtl/tabl_pkg.sv
// Shared definitions for the truth-table capture block: state encoding,
// default geometry and the table-depth macro.
`ifndef TABL_PKG_SV
`define TABL_PKG_SV

`define TABL_DEPTH(n) (1 << (n))

package tabl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2
    } state_t;

    localparam int N_IN_DEF   = 4;
    localparam int SETTLE_DEF = 2;

endpackage

`endif

// File: rtl/tabl_settle_cnt.sv
// Settle-time counter: counts while enabled, flags the last settle cycle.
module tabl_settle_cnt #(
    parameter int SETTLE = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [7:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 8'd1;
        end
    end

    assign tc = (cnt == 8'(SETTLE - 1));

endmodule

// File: rtl/tabl_capture.sv
// Truth-table capture: sweeps x_out over all inputs, samples y_in after a settle
// time. Optional float detection via TABL_CAPTURE_FLOAT_DETECT_EN.
module tabl_capture
    import tabl_pkg::*;
#(
    parameter int N_IN   = N_IN_DEF,
    parameter int SETTLE = SETTLE_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    output logic [N_IN-1:0]               x_out,
    input  logic                          y_in,
    output logic                          busy,
    output logic                          done,
    output logic [`TABL_DEPTH(N_IN)-1:0]  table_out,
    output logic [`TABL_DEPTH(N_IN)-1:0]  float_mask,
    output logic                          err
);

    localparam int DEPTH = `TABL_DEPTH(N_IN);
    localparam logic [N_IN-1:0] LAST = N_IN'(DEPTH - 1);

    state_t state;
    logic   fin;
    logic   tc;
    logic   cnt_en;
    logic   accept;
    logic   sample_bit;

    assign cnt_en = (state == ST_SETTLE);
    // fin holds the sweep open one extra cycle so done lands after the last sample
    assign accept = (state == ST_IDLE) && !fin && start;

    tabl_settle_cnt #(.SETTLE(SETTLE)) u_settle_cnt (
        .clk (clk),
        .rst (rst),
        .clr (!cnt_en),
        .en  (cnt_en),
        .tc  (tc)
    );

`ifdef TABL_CAPTURE_FLOAT_DETECT_EN
    logic                 is_float;
    logic [DEPTH-1:0]     mask_r;
    logic                 err_r;

    assign sample_bit = (y_in === 1'b1);
    assign is_float   = (y_in !== 1'b0) && (y_in !== 1'b1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask_r <= '0;
            err_r  <= 1'b0;
        end else if (accept) begin
            mask_r <= '0;
            err_r  <= 1'b0;
        end else if (state == ST_SAMPLE && is_float) begin
            mask_r[x_out] <= 1'b1;
            err_r         <= 1'b1;
        end
    end

    assign float_mask = mask_r;
    assign err        = err_r;
`else
    assign sample_bit = y_in;
    assign float_mask = '0;
    assign err        = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            fin       <= 1'b0;
            x_out     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            table_out <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (fin) begin
                        fin  <= 1'b0;
                        busy <= 1'b0;
                        done <= 1'b1;
                    end else if (start) begin
                        x_out     <= '0;
                        table_out <= '0;
                        busy      <= 1'b1;
                        state     <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (tc) begin
                        state <= ST_SAMPLE;
                    end
                end
                ST_SAMPLE: begin
                    table_out[x_out] <= sample_bit;
                    if (x_out == LAST) begin
                        fin   <= 1'b1;
                        state <= ST_IDLE;
                    end else begin
                        x_out <= x_out + 1'b1;
                        state <= ST_SETTLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
